cover_toggle_sched: RTL and testbench

//  Collects per-cycle toggle-hit vectors from N_GRP toggle-cover groups into sticky pending bits.

---
 rtl/cover_sched_pkg.sv | 23 ++
 rtl/cover_rr_pick.sv | 53 +++++
 rtl/cover_toggle_sched.sv | 136 +++++++++++++
 tb/tb_cover_toggle_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cover_sched_pkg.sv
// Shared types and helpers for the toggle-cover scheduler.
// Cover indices are built 64 bits wide, the width of a DPI longint.
package cover_sched_pkg;

    localparam int COALESCE_W = 16;
    localparam int CIDX_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [CIDX_W-1:0] cover_idx(
        input logic [CIDX_W-1:0] base,
        input int unsigned       g,
        input int unsigned       b,
        input int unsigned       grp_w
    );
        return base + CIDX_W'(g) * CIDX_W'(grp_w) + CIDX_W'(b);
    endfunction

endpackage

// File: rtl/cover_rr_pick.sv
// Combinational round-robin picker: the first non-empty group at or after rr,
// then the lowest pending bit inside that group.
module cover_rr_pick #(
    parameter int N_GRP = 4,
    parameter int GRP_W = 28,
    parameter int RR_W  = $clog2(N_GRP),
    parameter int BI_W  = (GRP_W > 1) ? $clog2(GRP_W) : 1
) (
    input  logic [N_GRP*GRP_W-1:0] i_pending,
    input  logic [RR_W-1:0]        i_rr,
    output logic                   o_any,
    output logic [RR_W-1:0]        o_grp,
    output logic [BI_W-1:0]        o_bit,
    output logic [N_GRP*GRP_W-1:0] o_grant
);

    logic [N_GRP-1:0] w_grp_any;
    logic [GRP_W-1:0] w_sel;
    logic             w_found;

    for (genvar g = 0; g < N_GRP; g++) begin : g_any
        assign w_grp_any[g] = |i_pending[g*GRP_W +: GRP_W];
    end

    assign o_any = |w_grp_any;

    always_comb begin
        o_grp   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_GRP; k++) begin
            if (!w_found && w_grp_any[(int'(i_rr) + k) % N_GRP]) begin
                w_found = 1'b1;
                o_grp   = RR_W'((int'(i_rr) + k) % N_GRP);
            end
        end
    end

    assign w_sel = i_pending[int'(o_grp)*GRP_W +: GRP_W];

    // Scan high-to-low so the last write wins with the lowest set bit.
    always_comb begin
        o_bit = '0;
        for (int b = GRP_W - 1; b >= 0; b--) begin
            if (w_sel[b]) o_bit = BI_W'(b);
        end
    end

    always_comb begin
        o_grant = '0;
        if (o_any) o_grant[int'(o_grp)*GRP_W + int'(o_bit)] = 1'b1;
    end

endmodule

// File: rtl/cover_toggle_sched.sv
// Collects toggle-cover hits into sticky pending bits and serialises them as a
// stream of cover indices over valid/ready, with coalesce counting and flush.
module cover_toggle_sched
    import cover_sched_pkg::*;
#(
    parameter int N_GRP       = 4,
    parameter int GRP_W       = 28,
    parameter int COVER_BASE  = 0,
    parameter int COVER_TOTAL = 8065,
    parameter int IDX_W       = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [N_GRP*GRP_W-1:0] i_hit,
    input  logic                   i_flush_req,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [IDX_W-1:0]       o_out_index,
    output logic                   o_busy,
    output logic                   o_flush_done,
    output logic [COALESCE_W-1:0]  o_coalesce_cnt
);

    localparam int NB   = N_GRP * GRP_W;
    localparam int RR_W = $clog2(N_GRP);
    localparam int BI_W = (GRP_W > 1) ? $clog2(GRP_W) : 1;
    localparam int PC_W = $clog2(NB + 1);

    if (COVER_BASE + NB > COVER_TOTAL) begin : g_bad_range
        $error("cover_toggle_sched: cover range exceeds COVER_TOTAL");
    end

    logic [NB-1:0]         r_pending;
    logic [RR_W-1:0]       r_rr;
    logic                  r_valid;
    logic [IDX_W-1:0]      r_index;
    state_t                r_state;
    logic                  r_flush_done;
    logic [COALESCE_W-1:0] r_coalesce;

    logic                  w_any;
    logic [RR_W-1:0]       w_grp;
    logic [BI_W-1:0]       w_bit;
    logic [NB-1:0]         w_pick;
    logic [NB-1:0]         w_grant;
    logic [NB-1:0]         w_cap;
    logic [NB-1:0]         w_pending_nxt;
    logic [NB-1:0]         w_coal_hits;
    logic [PC_W-1:0]       w_pop;
    logic [COALESCE_W:0]   w_sum;
    logic                  w_load;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_flush_ok;
    logic [IDX_W-1:0]      w_idx;

    cover_rr_pick #(
        .N_GRP (N_GRP),
        .GRP_W (GRP_W),
        .RR_W  (RR_W),
        .BI_W  (BI_W)
    ) u_pick (
        .i_pending (r_pending),
        .i_rr      (r_rr),
        .o_any     (w_any),
        .o_grp     (w_grp),
        .o_bit     (w_bit),
        .o_grant   (w_pick)
    );

    assign w_cap         = i_hit & {NB{i_enable}} & {NB{r_state != FLUSH}};
    assign w_load        = (!r_valid || i_out_ready) && w_any;
    assign w_grant       = w_load ? w_pick : '0;
    // A hit on the bit granted this cycle re-arms it rather than coalescing.
    assign w_pending_nxt = (r_pending & ~w_grant) | w_cap;
    assign w_coal_hits   = w_cap & r_pending & ~w_grant;
    assign w_valid_nxt   = w_load ? 1'b1 : (i_out_ready ? 1'b0 : r_valid);
    assign w_busy_nxt    = (|w_pending_nxt) || w_valid_nxt;
    assign w_flush_ok    = !(|r_pending) && (!r_valid || i_out_ready);
    assign w_idx         = IDX_W'(cover_idx(CIDX_W'(COVER_BASE), 32'(w_grp), 32'(w_bit), 32'(GRP_W)));

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NB; i++) begin
            w_pop = w_pop + PC_W'(w_coal_hits[i]);
        end
    end

    assign w_sum = {1'b0, r_coalesce} + (COALESCE_W+1)'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= '0;
            r_rr         <= '0;
            r_valid      <= 1'b0;
            r_index      <= '0;
            r_coalesce   <= '0;
            r_state      <= IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_valid      <= w_valid_nxt;
            r_coalesce   <= w_sum[COALESCE_W] ? {COALESCE_W{1'b1}} : w_sum[COALESCE_W-1:0];
            r_flush_done <= 1'b0;
            if (w_load) begin
                r_index <= w_idx;
                r_rr    <= (int'(w_grp) == N_GRP - 1) ? '0 : w_grp + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_flush_req)  r_state <= FLUSH;
                    else if (|w_cap)  r_state <= RUN;
                end
                RUN: begin
                    if (i_flush_req)      r_state <= FLUSH;
                    else if (!w_busy_nxt) r_state <= IDLE;
                end
                FLUSH: begin
                    if (w_flush_ok) begin
                        r_flush_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out_valid    = r_valid;
    assign o_out_index    = r_index;
    assign o_busy         = (|r_pending) || r_valid;
    assign o_flush_done   = r_flush_done;
    assign o_coalesce_cnt = r_coalesce;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched: latency, round-robin order, backpressure,
// coalescing, flush, full-vector drain with enable dropping, and async reset.
module tb_cover_toggle_sched;
    import cover_sched_pkg::*;

    localparam int N_GRP = 4;
    localparam int GRP_W = 28;
    localparam int NB    = N_GRP * GRP_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic [NB-1:0] hit = '0;
    logic          flush_req = 1'b0;
    logic          ready = 1'b1;
    logic          out_valid;
    logic [63:0]   out_index;
    logic          busy;
    logic          flush_done;
    logic [15:0]   coal;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] beats[$];

    always #5 clk = ~clk;

    cover_toggle_sched #(
        .N_GRP (N_GRP), .GRP_W (GRP_W), .COVER_BASE (0), .COVER_TOTAL (8065), .IDX_W (64)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_hit          (hit),
        .i_flush_req    (flush_req),
        .o_out_valid    (out_valid),
        .i_out_ready    (ready),
        .o_out_index    (out_index),
        .o_busy         (busy),
        .o_flush_done   (flush_done),
        .o_coalesce_cnt (coal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hit = '0; flush_req = 1'b0; enable = 1'b1; ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Accepted beats are recorded when sampled valid&&ready ahead of the edge.
    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        beats.delete();
        while (n < max_cyc) begin
            if (out_valid && ready) beats.push_back(out_index);
            if (!busy) break;
            step();
            n++;
        end
        chk("drain_bound", 64'(n < max_cyc), 64'd1);
    endtask

    initial begin
        int fd_at, last_acc;
        logic [63:0] exp5 [5];

        do_reset();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_index", out_index, 0);
        chk("rst_fdone", 64'(flush_done), 0);
        chk("rst_coal", 64'(coal), 0);
        chk("rst_busy", 64'(busy), 0);

        // single hit grp2 bit5 -> 61, valid two edges after the hit is sampled
        hit[2*GRP_W + 5] = 1'b1;
        step(); hit = '0;
        chk("t1_valid_t1", 64'(out_valid), 0);
        step();
        chk("t1_valid_t2", 64'(out_valid), 1);
        chk("t1_index", out_index, 61);
        step();
        chk("t1_valid_t3", 64'(out_valid), 0);
        chk("t1_index_hold", out_index, 61);
        chk("t1_busy", 64'(busy), 0);

        // round-robin with wrap from grp3 back to grp0
        do_reset();
        hit[0] = 1'b1; hit[1] = 1'b1; hit[28] = 1'b1; hit[111] = 1'b1;
        step(); hit = '0;
        drain(50);
        chk("t2_count", 64'(beats.size()), 4);
        if (beats.size() == 4) begin
            chk("t2_b0", beats[0], 0);
            chk("t2_b1", beats[1], 28);
            chk("t2_b2", beats[2], 111);
            chk("t2_b3", beats[3], 1);
        end
        chk("t2_rr", 64'(dut.r_rr), 1);

        // backpressure: first beat held stable for 10 cycles
        do_reset();
        ready = 1'b0;
        hit[2] = 1'b1; hit[33] = 1'b1; hit[63] = 1'b1;
        step(); hit = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 1);
            chk("t3_hold_index", out_index, 2);
            step();
        end
        ready = 1'b1;
        drain(50);
        chk("t3_count", 64'(beats.size()), 3);
        if (beats.size() == 3) begin
            chk("t3_b0", beats[0], 2);
            chk("t3_b1", beats[1], 33);
            chk("t3_b2", beats[2], 63);
        end
        chk("t3_busy", 64'(busy), 0);

        // coalesce: an earlier beat stalls the output, then grp1 bit3 hit 4 times
        do_reset();
        ready = 1'b0;
        hit[0] = 1'b1;
        step();
        hit = '0; hit[GRP_W + 3] = 1'b1;
        repeat (4) step();
        hit = '0;
        chk("t4_coal", 64'(coal), 3);
        ready = 1'b1;
        drain(50);
        chk("t4_count", 64'(beats.size()), 2);
        if (beats.size() == 2) begin
            chk("t4_b0", beats[0], 0);
            chk("t4_b1", beats[1], 31);
        end

        // flush with hits continuing during the drain
        do_reset();
        ready = 1'b0;
        hit[0] = 1'b1; hit[30] = 1'b1; hit[60] = 1'b1; hit[90] = 1'b1; hit[100] = 1'b1;
        step();
        hit = '0; flush_req = 1'b1;
        step();
        flush_req = 1'b0; hit = '1; ready = 1'b1;
        beats.delete(); fd_at = -1; last_acc = -1;
        for (int i = 0; i < 30; i++) begin
            if (flush_done) begin fd_at = i; break; end
            if (out_valid && ready) begin beats.push_back(out_index); last_acc = i; end
            step();
        end
        hit = '0;
        chk("t5_fdone_seen", 64'(fd_at >= 0), 1);
        chk("t5_fdone_time", 64'(fd_at), 64'(last_acc + 1));
        chk("t5_state", 64'(dut.r_state), 64'(IDLE));
        exp5 = '{64'd0, 64'd30, 64'd60, 64'd90, 64'd100};
        chk("t5_count", 64'(beats.size()), 5);
        if (beats.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t5_beat", beats[i], exp5[i]);
        end
        step();
        chk("t5_fdone_pulse", 64'(flush_done), 0);
        chk("t5_busy", 64'(busy), 0);

        // flush with nothing pending
        flush_req = 1'b1;
        step(); flush_req = 1'b0;
        chk("t5i_fd0", 64'(flush_done), 0);
        step();
        chk("t5i_fd1", 64'(flush_done), 1);
        step();
        chk("t5i_fd2", 64'(flush_done), 0);

        // every bit at once; enable drops after 10 beats while hits stay asserted
        do_reset();
        hit = '1;
        step(); hit = '0;
        beats.delete();
        for (int i = 0; i < 400; i++) begin
            if (out_valid && ready) begin
                beats.push_back(out_index);
                if (beats.size() == 10) begin enable = 1'b0; hit = '1; end
            end
            if (!busy) break;
            step();
        end
        hit = '0; enable = 1'b1;
        chk("t7_count", 64'(beats.size()), 64'(NB));
        if (beats.size() == NB) begin
            for (int k = 0; k < NB; k++)
                chk("t7_beat", beats[k], 64'((k % N_GRP) * GRP_W + k / N_GRP));
        end

        // async reset mid-drain
        do_reset();
        for (int i = 0; i < 20; i++) hit[i] = 1'b1;
        step(); step();
        hit = '0;
        chk("t6_coal_pre", 64'(coal), 19);
        step();
        chk("t6_valid_pre", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_coal", 64'(coal), 0);
        chk("t6_rr", 64'(dut.r_rr), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_busy_after", 64'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
